// File: rtl/dram_pkg.sv
// Shared definitions for the DataRam b-port arbiter.
package dram_pkg;

    localparam int ADDR_W = 30;
    localparam int BE_W   = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; an active lock restricts eligibility to its owner.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       rr_i,
    input  logic       lock_en_i,
    input  logic       lock_owner_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (lock_en_i) begin
            grant_o[lock_owner_i] = 1'b1;
        end else if (valid_i == 2'b11) begin
            grant_o[rr_i] = 1'b1;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/dram_portb_arbiter.sv
// Shares DataRam port b between the debug module (r0) and the init/dump loader (r1).
// Handshake: a beat transfers in the cycle req_valid[i] & req_ready[i]; its response strobes exactly one cycle later.
module dram_portb_arbiter
    import dram_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [BE_W-1:0]   req_we0,
    input  logic [BE_W-1:0]   req_we1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              lock_abort,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dinb,
    output logic [BE_W-1:0]   web,
    input  logic [DATA_W-1:0] doutb,
    output logic [1:0]        dbg_state
);

    arb_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic        rr_q, rr_d;
    logic        abort_q, abort_d;
    logic [1:0]  resp_valid_q;
    logic [1:0]  grant;
    logic        accept;
    logic        sel;
    logic        beat_lock;

    rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .rr_i         (rr_q),
        .lock_en_i    (state_q != ST_IDLE),
        .lock_owner_i (state_q == ST_LOCK1),
        .grant_o      (grant)
    );

    assign req_ready = req_valid & grant;
    assign accept    = |req_ready;
    assign sel       = req_ready[1];
    assign beat_lock = req_lock[sel];
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        abort_d = 1'b0;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                rr_d = ~sel;
                if (beat_lock) begin
                    // A one-beat lock budget is exhausted by the very beat that requests it.
                    if (LOCK_MAX == 1) begin
                        abort_d = 1'b1;
                    end else begin
                        state_d = sel ? ST_LOCK1 : ST_LOCK0;
                        cnt_d   = 8'd1;
                    end
                end
            end else if (cnt_inc == 9'(LOCK_MAX)) begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                rr_d    = ~sel;
                abort_d = 1'b1;
            end else if (!beat_lock) begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                rr_d    = ~sel;
            end else begin
                cnt_d = cnt_inc[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            rr_q         <= 1'b0;
            abort_q      <= 1'b0;
            resp_valid_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            abort_q      <= abort_d;
            resp_valid_q <= req_ready;
        end
    end

    assign addrb      = accept ? (sel ? req_addr1 : req_addr0) : '0;
    assign dinb       = accept ? (sel ? req_wdata1 : req_wdata0) : '0;
    assign web        = accept ? (sel ? req_we1 : req_we0) : '0;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = (|resp_valid_q) ? doutb : '0;
    assign lock_abort = abort_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dram_portb_arbiter.sv
// Directed bench for dram_portb_arbiter with a behavioural DataRam b port model.
module tb_dram_portb_arbiter;
  import dram_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_lock;
  logic [29:0] req_addr0, req_addr1;
  logic [3:0]  req_we0, req_we1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        lock_abort;
  logic [29:0] addrb;
  logic [31:0] dinb;
  logic [3:0]  web;
  logic [31:0] doutb;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;

  logic [31:0] mem [0:15];

  dram_portb_arbiter #(.LOCK_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lock   (req_lock),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_we0    (req_we0),
    .req_we1    (req_we1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .lock_abort (lock_abort),
    .addrb      (addrb),
    .dinb       (dinb),
    .web        (web),
    .doutb      (doutb),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataRam b: byte-enabled write and registered read on the same edge
  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 32'h1c + 32'(k);
    doutb = 32'h0;
  end

  always @(posedge clk) begin
    doutb <= mem[addrb[3:0]];
    for (int b = 0; b < 4; b++) begin
      if (web[b]) mem[addrb[3:0]][b*8 +: 8] <= dinb[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    req_valid  = 2'b00;
    req_lock   = 2'b00;
    req_addr0  = '0;
    req_addr1  = '0;
    req_we0    = '0;
    req_we1    = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_idle();
    repeat (3) cyc();

    // reset state
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_abort", 32'(lock_abort), 32'h0);
    chk("rst_addrb", 32'(addrb), 32'h0);
    chk("rst_dinb", dinb, 32'h0);
    chk("rst_web", 32'(web), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    cyc();

    // single read by r0 at address 0
    req_valid = 2'b01;
    req_addr0 = 30'd0;
    #1;
    chk("r0_rd_ready", 32'(req_ready), 32'h1);
    chk("r0_rd_web", 32'(web), 32'h0);
    cyc();
    drive_idle();
    chk("r0_rd_resp_valid", 32'(resp_valid), 32'h1);
    chk("r0_rd_rdata", resp_rdata, 32'h0000001c);
    #1;
    chk("no_beat_web", 32'(web), 32'h0);
    chk("no_beat_addrb", 32'(addrb), 32'h0);

    // r1 byte write then read-back on the next beat
    req_valid  = 2'b10;
    req_addr1  = 30'd1;
    req_we1    = 4'b0001;
    req_wdata1 = 32'hAABBCCDD;
    #1;
    chk("r1_wr_ready", 32'(req_ready), 32'h2);
    chk("r1_wr_addrb", 32'(addrb), 32'h1);
    chk("r1_wr_dinb", dinb, 32'hAABBCCDD);
    chk("r1_wr_web", 32'(web), 32'h1);
    cyc();
    chk("r1_wr_resp_valid", 32'(resp_valid), 32'h2);
    req_we1    = 4'b0000;
    req_wdata1 = 32'h0;
    cyc();
    drive_idle();
    chk("r1_raw_resp_valid", 32'(resp_valid), 32'h2);
    chk("r1_raw_rdata", resp_rdata, 32'h000000DD);

    // both valid, no lock: strict alternation starting at r0
    req_valid = 2'b11;
    req_addr0 = 30'd2;
    req_addr1 = 30'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_addrb", 32'(addrb), (k % 2 == 0) ? 32'h2 : 32'h3);
      cyc();
      chk("alt_resp_valid", 32'(resp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_rdata", resp_rdata, (k % 2 == 0) ? 32'h1e : 32'h1f);
    end

    // r0 holds lock for 3 beats while r1 waits
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      req_lock = (k < 2) ? 2'b01 : 2'b00;
      #1;
      chk("lock3_ready", 32'(req_ready), 32'h1);
      cyc();
      chk("lock3_state", 32'(dbg_state), (k < 2) ? 32'(ST_LOCK0) : 32'(ST_IDLE));
    end
    req_lock = 2'b00;
    #1;
    chk("lock3_r1_grant", 32'(req_ready), 32'h2);
    cyc();

    // forced release at LOCK_MAX=4
    req_valid = 2'b11;
    req_lock  = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lockmax_ready", 32'(req_ready), 32'h1);
      cyc();
      chk("lockmax_abort", 32'(lock_abort), (k == 3) ? 32'h1 : 32'h0);
    end
    chk("lockmax_state", 32'(dbg_state), 32'(ST_IDLE));
    #1;
    chk("lockmax_r1_grant", 32'(req_ready), 32'h2);
    cyc();
    chk("lockmax_abort_clr", 32'(lock_abort), 32'h0);
    drive_idle();

    // reset asserted in LOCK1 with a read response pending
    req_valid = 2'b10;
    req_lock  = 2'b10;
    req_addr1 = 30'd5;
    cyc();
    chk("lock1_state", 32'(dbg_state), 32'(ST_LOCK1));
    req_valid = 2'b11;
    #1;
    chk("lock1_blocks_r0", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    chk("lock1_resp_pending", 32'(resp_valid), 32'h2);
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("async_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("async_rst_web", 32'(web), 32'h0);
    chk("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("async_rst_rdata", resp_rdata, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    req_valid = 2'b11;
    req_lock  = 2'b00;
    #1;
    chk("post_rst_r0_first", 32'(req_ready), 32'h1);
    cyc();
    drive_idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
